// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage: forwarding, ALU and EX/MEM pipeline register
module execute_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_e,
    input  logic [2:0]       alucontrol_e,
    input  logic [WIDTH-1:0] rd1_e,
    input  logic [WIDTH-1:0] rd2_e,
    input  logic [WIDTH-1:0] signimm_e,
    input  logic             alusrc_e,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic             memwrite_e,
    input  logic [REGW-1:0]  writereg_e,
    input  logic [1:0]       forwarda_e,
    input  logic [1:0]       forwardb_e,
    input  logic [WIDTH-1:0] result_w,
    input  logic             stall_e,
    input  logic             flush_e,
    output logic             valid_m,
    output logic             regwrite_m,
    output logic             memtoreg_m,
    output logic             memwrite_m,
    output logic [WIDTH-1:0] aluout_m,
    output logic [WIDTH-1:0] writedata_m,
    output logic [REGW-1:0]  writereg_m,
    output logic             zero_m,
    output logic             overflow_m
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NONE = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic             valid_q, regwrite_q, memtoreg_q, memwrite_q, zero_q, overflow_q;
    logic [WIDTH-1:0] aluout_q, writedata_q;
    logic [REGW-1:0]  writereg_q;

    logic             valid_d, regwrite_d, memtoreg_d, memwrite_d, zero_d, overflow_d;
    logic [WIDTH-1:0] aluout_d, writedata_d;
    logic [REGW-1:0]  writereg_d;

    logic [WIDTH-1:0] srca, fwd_b, srcb, alu_y, sum, diff;
    logic             alu_ovf;

    // Operand forwarding; select 11 behaves like 00 (register-file data)
    always_comb begin
        case (forwarda_e)
            2'b01:   srca = result_w;
            2'b10:   srca = aluout_q;
            default: srca = rd1_e;
        endcase
        case (forwardb_e)
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = aluout_q;
            default: fwd_b = rd2_e;
        endcase
        srcb = alusrc_e ? signimm_e : fwd_b;
    end

    // ALU with signed overflow flag for add/sub
    always_comb begin
        sum     = srca + srcb;
        diff    = srca - srcb;
        alu_y   = '0;
        alu_ovf = 1'b0;
        case (alucontrol_e)
            OP_AND:  alu_y = srca & srcb;
            OP_OR:   alu_y = srca | srcb;
            OP_ADD: begin
                alu_y   = sum;
                alu_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_NONE: alu_y = '0;
            OP_ANDN: alu_y = srca & ~srcb;
            OP_ORN:  alu_y = srca | ~srcb;
            OP_SUB: begin
                alu_y   = diff;
                alu_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_y = '0;
        endcase
    end

    // EX/MEM next state: flush beats stall; an invalid instruction loads a bubble
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        memwrite_d  = memwrite_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        aluout_d    = aluout_q;
        writedata_d = writedata_q;
        writereg_d  = writereg_q;
        if (flush_e || (!stall_e && !valid_e)) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
            memwrite_d  = 1'b0;
            zero_d      = 1'b0;
            overflow_d  = 1'b0;
            aluout_d    = '0;
            writedata_d = '0;
            writereg_d  = '0;
        end else if (!stall_e) begin
            valid_d     = 1'b1;
            regwrite_d  = regwrite_e;
            memtoreg_d  = memtoreg_e;
            memwrite_d  = memwrite_e;
            zero_d      = (alu_y == '0);
            overflow_d  = alu_ovf;
            aluout_d    = alu_y;
            writedata_d = fwd_b;
            writereg_d  = writereg_e;
        end
    end

    // EX/MEM pipeline register, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            aluout_q    <= '0;
            writedata_q <= '0;
            writereg_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            memwrite_q  <= memwrite_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            aluout_q    <= aluout_d;
            writedata_q <= writedata_d;
            writereg_q  <= writereg_d;
        end
    end

    assign valid_m     = valid_q;
    assign regwrite_m  = regwrite_q;
    assign memtoreg_m  = memtoreg_q;
    assign memwrite_m  = memwrite_q;
    assign zero_m      = zero_q;
    assign overflow_m  = overflow_q;
    assign aluout_m    = aluout_q;
    assign writedata_m = writedata_q;
    assign writereg_m  = writereg_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized model-checked bench for execute_stage
module tb_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_e;
    logic [2:0]  alucontrol_e;
    logic [31:0] rd1_e, rd2_e, signimm_e, result_w;
    logic        alusrc_e, regwrite_e, memtoreg_e, memwrite_e;
    logic [4:0]  writereg_e;
    logic [1:0]  forwarda_e, forwardb_e;
    logic        stall_e, flush_e;
    logic        valid_m, regwrite_m, memtoreg_m, memwrite_m, zero_m, overflow_m;
    logic [31:0] aluout_m, writedata_m;
    logic [4:0]  writereg_m;

    execute_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .alucontrol_e(alucontrol_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .signimm_e(signimm_e), .alusrc_e(alusrc_e),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
        .writereg_e(writereg_e), .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
        .result_w(result_w), .stall_e(stall_e), .flush_e(flush_e),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .memwrite_m(memwrite_m), .aluout_m(aluout_m), .writedata_m(writedata_m),
        .writereg_m(writereg_m), .zero_m(zero_m), .overflow_m(overflow_m)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    // reference EX/MEM contents
    logic [31:0] m_al = 0, m_wd = 0;
    logic [4:0]  m_wr = 0;
    logic        m_v = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_z = 0, m_o = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU from arithmetic meaning: overflow = true result outside signed 32-bit range
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic ov);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 0;
        case (op)
            3'd2: begin r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); return a + b; end
            3'd6: begin r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); return a - b; end
            3'd0: return a & b;
            3'd1: return a | b;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_z = 0; m_o = 0;
        m_al = 0; m_wd = 0; m_wr = 0;
    endtask

    function automatic logic [31:0] pick_src(input logic [1:0] f, input logic [31:0] rd);
        if (f == 2'd1) return result_w;
        if (f == 2'd2) return m_al;
        return rd;
    endfunction

    // model of the EX/MEM register
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] a, b, y;
        logic ov;
        if (!rst_n || flush_e) model_clear();
        else if (stall_e) begin end
        else if (!valid_e) model_clear();
        else begin
            a = pick_src(forwarda_e, rd1_e);
            b = pick_src(forwardb_e, rd2_e);
            y = ref_alu(alucontrol_e, a, alusrc_e ? signimm_e : b, ov);
            m_v = 1; m_rw = regwrite_e; m_mr = memtoreg_e; m_mw = memwrite_e;
            m_al = y; m_wd = b; m_wr = writereg_e; m_z = (y == 0); m_o = ov;
        end
    end

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("valid_m", valid_m, m_v);
            chk("regwrite_m", regwrite_m, m_rw);
            chk("memtoreg_m", memtoreg_m, m_mr);
            chk("memwrite_m", memwrite_m, m_mw);
            chk("aluout_m", aluout_m, m_al);
            chk("writedata_m", writedata_m, m_wd);
            chk("writereg_m", writereg_m, m_wr);
            chk("zero_m", zero_m, m_z);
            chk("overflow_m", overflow_m, m_o);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_e = 1; alucontrol_e = op; rd1_e = a; rd2_e = b; signimm_e = 0;
        alusrc_e = 0; forwarda_e = 0; forwardb_e = 0; stall_e = 0; flush_e = 0;
        regwrite_e = 1; memtoreg_e = 0; memwrite_e = 0; writereg_e = 5'd3; result_w = 0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {valid_m, regwrite_m, memtoreg_m, memwrite_m, zero_m, overflow_m}, 6'd0);
        chk({tag, "_alu"}, aluout_m, 32'd0);
        chk({tag, "_wd"}, writedata_m, 32'd0);
        chk({tag, "_wr"}, writereg_m, 5'd0);
    endtask

    initial begin
        rst_n = 0;
        setop(3'd2, 32'h11, 32'h22);
        go();
        check_all_zero("reset_init");
        rst_n = 1;
        checking = 1;

        setop(3'd2, 32'h7FFFFFFF, 32'd1); go();
        chk("add_ovf_val", aluout_m, 32'h80000000);
        chk("add_ovf_flag", overflow_m, 1'b1);
        setop(3'd6, 32'd5, 32'd5); go();
        chk("sub_zero_val", aluout_m, 32'd0);
        chk("sub_zero_flag", zero_m, 1'b1);
        setop(3'd7, 32'hFFFFFFFF, 32'd1); go();
        chk("slt_signed", aluout_m, 32'd1);
        setop(3'd0, 32'hF0F0F0F0, 32'h0FF00FF0); go();
        chk("and", aluout_m, 32'h00F000F0);
        setop(3'd1, 32'hF0F0F0F0, 32'h0FF00FF0); go();
        chk("or", aluout_m, 32'hFFF0FFF0);
        setop(3'd3, 32'h12345678, 32'h9); go();
        chk("op011", aluout_m, 32'd0);

        setop(3'd2, 32'd10, 32'h1234); alusrc_e = 1; signimm_e = 32'hFFFFFFFC; go();
        chk("imm_add", aluout_m, 32'd6);
        chk("imm_wd", writedata_m, 32'h1234);

        setop(3'd2, 32'd1, 32'd2); go();
        chk("fwd_base", aluout_m, 32'd3);
        setop(3'd2, 32'd99, 32'd4); forwarda_e = 2'b10; go();
        chk("fwd_a_mem", aluout_m, 32'd7);
        setop(3'd2, 32'd1, 32'd4); forwardb_e = 2'b01; result_w = 32'd20; go();
        chk("fwd_b_wb", aluout_m, 32'd21);
        chk("fwd_b_wd", writedata_m, 32'd20);

        setop(3'd2, 32'd100, 32'd23); writereg_e = 5'd9; go();
        chk("pre_stall", aluout_m, 32'd123);
        setop(3'd6, 32'd1, 32'd1); forwarda_e = 2'b10; stall_e = 1; writereg_e = 5'd4;
        for (int i = 0; i < 3; i++) begin
            go();
            chk("stall_hold_alu", aluout_m, 32'd123);
            chk("stall_hold_wr", writereg_m, 5'd9);
        end
        setop(3'd2, 32'd0, 32'd1); forwarda_e = 2'b10; go();
        chk("post_stall_fwd", aluout_m, 32'd124);

        setop(3'd2, 32'd5, 32'd6); memwrite_e = 1; stall_e = 1; flush_e = 1; go();
        chk("flush_over_stall", {valid_m, regwrite_m, memwrite_m}, 3'd0);
        setop(3'd2, 32'd5, 32'd6); memwrite_e = 1; valid_e = 0; go();
        chk("invalid_bubble", {valid_m, memwrite_m}, 2'd0);

        setop(3'd5, 32'h0, 32'h0F); memtoreg_e = 1; memwrite_e = 1; writereg_e = 5'd31; go();
        chk("orn_val", aluout_m, 32'hFFFFFFF0);
        #3 rst_n = 0;
        #1 check_all_zero("reset_mid");
        go();
        rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            valid_e      = ($urandom_range(0, 7) != 0);
            alucontrol_e = 3'($urandom_range(0, 7));
            rd1_e        = rnd_val();
            rd2_e        = rnd_val();
            signimm_e    = rnd_val();
            result_w     = rnd_val();
            alusrc_e     = 1'($urandom_range(0, 1));
            regwrite_e   = 1'($urandom_range(0, 1));
            memtoreg_e   = 1'($urandom_range(0, 1));
            memwrite_e   = 1'($urandom_range(0, 1));
            writereg_e   = 5'($urandom);
            forwarda_e   = 2'($urandom_range(0, 3));
            forwardb_e   = 2'($urandom_range(0, 3));
            stall_e      = ($urandom_range(0, 7) == 0);
            flush_e      = ($urandom_range(0, 15) == 0);
            go();
        end

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
